// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants (receiver and transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int WORD_LENGTH        = 8;
   localparam int DEFAULT_OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Counter value at which the start bit is at its midpoint.
   function automatic int mid_sample_count(input int oversample);
      return (oversample / 2) - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync
// Description : Two-flop synchronizer for an idle-high asynchronous line.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver with one-deep holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
   parameter int OVERSAMPLE  = uart_pkg::DEFAULT_OVERSAMPLE,
   parameter int WORD_LENGTH = uart_pkg::WORD_LENGTH
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_ce,
   input  logic       i_rx,
   input  logic       i_re,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_ferr,
   output logic       o_ovr,
   output logic       o_busy
);

   import uart_pkg::*;

   localparam int c_cnt_w = $clog2(OVERSAMPLE);
   localparam int c_bit_w = $clog2(WORD_LENGTH);

   localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(mid_sample_count(OVERSAMPLE));
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(OVERSAMPLE - 1);
   localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WORD_LENGTH - 1);

   state_t                   r_state;
   logic [c_cnt_w-1:0]       r_cnt;
   logic [c_bit_w-1:0]       r_bit;
   logic [WORD_LENGTH-1:0]   r_shift;
   logic [7:0]               r_data;
   logic                     r_valid;
   logic                     r_ferr;
   logic                     r_ovr;
   logic                     r_busy;

   logic                     w_rx_s;
   logic [7:0]               w_word;

   uart_sync u_sync (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (w_rx_s)
   );

   // The holding register is always a byte wide regardless of frame length.
   generate
      if (WORD_LENGTH >= 8) begin : g_word_trunc
         assign w_word = r_shift[7:0];
      end else begin : g_word_pad
         assign w_word = {{(8 - WORD_LENGTH){1'b0}}, r_shift};
      end
   endgenerate

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;

         // A read acknowledge is overridden below if a new byte lands this cycle.
         if (i_re && r_valid) begin
            r_valid <= 1'b0;
         end

         if (i_ce) begin
            case (r_state)
               IDLE: begin
                  if (!w_rx_s) begin
                     r_state <= START;
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                  end
               end

               START: begin
                  if (r_cnt == c_cnt_half) begin
                     r_cnt <= '0;
                     if (!w_rx_s) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                     end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               DATA: begin
                  if (r_cnt == c_cnt_last) begin
                     r_cnt   <= '0;
                     r_shift <= {w_rx_s, r_shift[WORD_LENGTH-1:1]};
                     if (r_bit == c_bit_last) begin
                        r_state <= STOP;
                        r_bit   <= '0;
                     end else begin
                        r_bit <= r_bit + 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               STOP: begin
                  if (r_cnt == c_cnt_last) begin
                     r_cnt   <= '0;
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     if (w_rx_s) begin
                        if (!r_valid || i_re) begin
                           r_data  <= w_word;
                           r_valid <= 1'b1;
                        end else begin
                           r_ovr <= 1'b1;
                        end
                     end else begin
                        r_ferr <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               default: begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_ferr  = r_ferr;
   assign o_ovr   = r_ovr;
   assign o_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (vector table + event scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   logic       i_clock = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_ce    = 1'b0;
   logic       i_rx    = 1'b1;
   logic       i_re    = 1'b0;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_ferr;
   logic       o_ovr;
   logic       o_busy;

   uart_rx #(
      .OVERSAMPLE  (16),
      .WORD_LENGTH (8)
   ) dut (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_ce    (i_ce),
      .i_rx    (i_rx),
      .i_re    (i_re),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_ferr  (o_ferr),
      .o_ovr   (o_ovr),
      .o_busy  (o_busy)
   );

   always #5 i_clock = ~i_clock;

   typedef enum int {EV_NONE, EV_LOAD, EV_FERR, EV_OVR} ev_t;

   typedef struct {
      ev_t        kind;
      logic [7:0] data;
      int         tick;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      bit         stop;
      bit         re_load;
      bit         re_after;
      ev_t        ev;
      logic [7:0] exp_data;
      bit         exp_valid;
   } vec_t;

   exp_t       sb[$];
   vec_t       vecs[9];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         div     = 0;
   int         tick_no = 0;
   int         cur_tick = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic observe(input ev_t kind);
      exp_t e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event: got %s at tick %0d, expected none", kind.name(), tick_no);
      end else begin
         e = sb.pop_front();
         chk("event_kind", kind, e.kind);
         if (kind == EV_LOAD) chk("event_data", o_data, e.data);
         chk("event_tick", (i_ce === 1'b1) ? tick_no : -1, e.tick);
      end
   endtask

   // Monitor first (sees the tick the DUT just used), then advance the tick generator.
   always @(negedge i_clock) begin
      if (o_valid === 1'b1 && (prev_valid !== 1'b1 || o_data !== prev_data)) observe(EV_LOAD);
      if (o_ferr === 1'b1) observe(EV_FERR);
      if (o_ovr === 1'b1)  observe(EV_OVR);
      prev_valid = o_valid;
      prev_data  = o_data;
      div  = (div == 3) ? 0 : div + 1;
      i_ce = (div == 0);
      if (i_ce) tick_no = tick_no + 1;
   end

   task automatic next_tick();
      do @(posedge i_clock); while (i_ce !== 1'b1);
      #1 cur_tick = tick_no;
   endtask

   task automatic wait_tick(input int t);
      do next_tick(); while (cur_tick < t);
   endtask

   task automatic pulse_re();
      @(posedge i_clock);
      #1 i_re = 1'b1;
      @(posedge i_clock);
      #1 i_re = 1'b0;
   endtask

   // Frame starts after tick k: first detection at k+1, stop sampled at k+1+8+16*9.
   task automatic send_frame(input logic [7:0] d, input bit stop, input bit re_load,
                             input ev_t ev, input logic [7:0] ev_data);
      int         k;
      logic [9:0] bits;
      exp_t       e;
      next_tick();
      k    = cur_tick;
      bits = {stop, d, 1'b0};
      if (ev != EV_NONE) begin
         e.kind = ev;
         e.data = ev_data;
         e.tick = k + 153;
         sb.push_back(e);
      end
      for (int b = 0; b < 10; b++) begin
         if (b > 0) wait_tick(k + 16 * b);
         i_rx = bits[b];
      end
      if (re_load) begin
         wait_tick(k + 152);
         repeat (3) @(posedge i_clock);
         #1 i_re = 1'b1;
         @(posedge i_clock);
         #1 i_re = 1'b0;
      end
      wait_tick(k + 160);
      i_rx = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         k;
      logic [9:0] bits;

      vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b1, EV_LOAD, 8'h55, 1'b1};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1, EV_LOAD, 8'hA5, 1'b1};
      vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, EV_LOAD, 8'h3C, 1'b1};
      vecs[3] = '{8'h81, 1'b0, 1'b0, 1'b0, EV_FERR, 8'h3C, 1'b0};
      vecs[4] = '{8'h11, 1'b1, 1'b0, 1'b0, EV_LOAD, 8'h11, 1'b1};
      vecs[5] = '{8'h22, 1'b1, 1'b0, 1'b1, EV_OVR,  8'h11, 1'b1};
      vecs[6] = '{8'h11, 1'b1, 1'b0, 1'b0, EV_LOAD, 8'h11, 1'b1};
      vecs[7] = '{8'h22, 1'b1, 1'b1, 1'b0, EV_LOAD, 8'h22, 1'b1};
      vecs[8] = '{8'h00, 1'b0, 1'b0, 1'b1, EV_FERR, 8'h22, 1'b1};

      repeat (4) @(posedge i_clock);
      #1;
      chk("reset_data",  o_data,  8'h00);
      chk("reset_valid", o_valid, 1'b0);
      chk("reset_ferr",  o_ferr,  1'b0);
      chk("reset_ovr",   o_ovr,   1'b0);
      chk("reset_busy",  o_busy,  1'b0);
      i_reset = 1'b0;
      repeat (3) next_tick();

      for (int i = 0; i < 9; i++) begin
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].re_load, vecs[i].ev,
                    vecs[i].exp_data);
         repeat (4) next_tick();
         chk($sformatf("vec%0d_data", i),  o_data,  vecs[i].exp_data);
         chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].exp_valid);
         chk($sformatf("vec%0d_busy", i),  o_busy,  1'b0);
         if (vecs[i].re_after) begin
            pulse_re();
            @(negedge i_clock);
            chk($sformatf("vec%0d_valid_after_re", i), o_valid, 1'b0);
         end
         repeat (4) next_tick();
      end

      // Four-tick low glitch on an idle line is rejected at the start midpoint.
      next_tick();
      k    = cur_tick;
      i_rx = 1'b0;
      wait_tick(k + 4);
      i_rx = 1'b1;
      chk("glitch_busy_high", o_busy, 1'b1);
      wait_tick(k + 12);
      chk("glitch_busy_low", o_busy,  1'b0);
      chk("glitch_valid",    o_valid, 1'b0);
      chk("glitch_data",     o_data,  8'h22);

      // Reset in the middle of bit 3 of 0xF0, then a clean 0x0F frame.
      next_tick();
      k    = cur_tick;
      bits = {1'b1, 8'hF0, 1'b0};
      for (int b = 0; b < 4; b++) begin
         if (b > 0) wait_tick(k + 16 * b);
         i_rx = bits[b];
      end
      wait_tick(k + 72);
      chk("midframe_busy", o_busy, 1'b1);
      i_reset = 1'b1;
      i_rx    = 1'b1;
      repeat (2) @(posedge i_clock);
      #1 i_reset = 1'b0;
      @(negedge i_clock);
      chk("abort_busy",  o_busy,  1'b0);
      chk("abort_valid", o_valid, 1'b0);
      chk("abort_data",  o_data,  8'h00);
      repeat (20) next_tick();
      chk("abort_idle", o_busy, 1'b0);
      send_frame(8'h0F, 1'b1, 1'b0, EV_LOAD, 8'h0F);
      repeat (4) next_tick();
      chk("post_reset_data",  o_data,  8'h0F);
      chk("post_reset_valid", o_valid, 1'b1);

      repeat (4) next_tick();
      chk("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
